// File: rtl/clip_sequencer.sv
// clip_sequencer: multi-clip sample player driving the shared sample ROM address
// and the left audio channel. Lower clip index = higher priority.
module clip_sequencer #(
   parameter int unsigned ADDR_W    = 18,
   parameter int unsigned SAMPLE_W  = 6,
   parameter int unsigned NUM_CLIPS = 4,
   parameter int unsigned SEL_W     = 2,
   parameter int unsigned RATE_DIV  = 1200,
   parameter int unsigned ROM_LAT   = 1,
   parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_STARTS =
      {18'd83255, 18'd66983, 18'd16396, 18'd0},
   parameter logic [NUM_CLIPS*ADDR_W-1:0] CLIP_ENDS =
      {18'd137138, 18'd83254, 18'd66982, 18'd16395}
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic                trigger,
   input  logic [SEL_W-1:0]    clip_sel,
   input  logic                loop_en,
   input  logic                stop,
   output logic [ADDR_W-1:0]   rom_address,
   input  logic [SAMPLE_W-1:0] rom_q,
   input  logic                audio_out_allowed,
   output logic                write_audio_out,
   output logic [31:0]         left_channel_audio_out,
   output logic                busy,
   output logic [SEL_W-1:0]    active_clip,
   output logic                done
);

   localparam int unsigned CNT_W = $clog2(RATE_DIV);
   localparam int unsigned SEL_N = 2 ** SEL_W;
   localparam int unsigned PAD_W = 32 - SAMPLE_W;

   typedef enum logic {IDLE, PLAY} state_t;

   state_t              state;
   logic [CNT_W-1:0]    rate_cnt;
   logic [SAMPLE_W-1:0] sample_reg;
   logic [ROM_LAT-1:0]  strobe_pipe;
   logic                loop_flag;

   logic [ADDR_W-1:0]   start_tab [SEL_N];
   logic [ADDR_W-1:0]   end_tab   [SEL_N];

   logic                in_play_c;
   logic                sel_valid_c;
   logic                start_c;
   logic                stop_c;
   logic                tc_c;
   logic                at_end_c;
   logic                step_c;
   logic                finish_c;
   logic                flush_c;
   logic                load_c;
   logic [ROM_LAT-1:0]  pipe_keep_c;
   logic [ROM_LAT-1:0]  pipe_nxt_c;
   logic [SAMPLE_W-1:0] sample_nxt_c;

   // Unpack the clip tables; unused select codes map to address 0 and are never started
   for (genvar i = 0; i < SEL_N; i++) begin : g_tab
      if (i < NUM_CLIPS) begin : g_used
         assign start_tab[i] = CLIP_STARTS[i*ADDR_W +: ADDR_W];
         assign end_tab[i]   = CLIP_ENDS[i*ADDR_W +: ADDR_W];
      end else begin : g_pad
         assign start_tab[i] = '0;
         assign end_tab[i]   = '0;
      end
   end

   // Event decode: stop beats trigger, trigger beats the terminal-count step
   assign in_play_c   = (state == PLAY);
   assign sel_valid_c = ({1'b0, clip_sel} < (SEL_W+1)'(NUM_CLIPS));
   assign start_c     = trigger & sel_valid_c & ~stop &
                        (~in_play_c | (clip_sel <= active_clip));
   assign stop_c      = in_play_c & stop;
   assign tc_c        = in_play_c & (rate_cnt == CNT_W'(RATE_DIV - 1));
   assign at_end_c    = (rom_address == end_tab[active_clip]);
   assign step_c      = tc_c & ~stop_c & ~start_c & (~at_end_c | loop_flag);
   assign finish_c    = tc_c & ~stop_c & ~start_c & at_end_c & ~loop_flag;
   assign flush_c     = stop_c | (start_c & in_play_c);

   // Strobe pipeline marks when rom_q reflects the latest address update
   assign pipe_keep_c  = flush_c ? '0 : strobe_pipe;
   assign pipe_nxt_c   = ROM_LAT'({pipe_keep_c, start_c | step_c});
   assign load_c       = strobe_pipe[ROM_LAT-1] & ~flush_c;
   assign sample_nxt_c = stop_c ? '0 : (load_c ? rom_q : sample_reg);

   // Playback FSM with address stepping, sample capture and registered outputs
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state                  <= IDLE;
         rom_address            <= '0;
         rate_cnt               <= '0;
         sample_reg             <= '0;
         strobe_pipe            <= '0;
         loop_flag              <= 1'b0;
         write_audio_out        <= 1'b0;
         left_channel_audio_out <= '0;
         busy                   <= 1'b0;
         active_clip            <= '0;
         done                   <= 1'b0;
      end else begin
         strobe_pipe     <= pipe_nxt_c;
         sample_reg      <= sample_nxt_c;
         done            <= 1'b0;
         write_audio_out <= audio_out_allowed & busy;
         if (start_c) begin
            state                  <= PLAY;
            rom_address            <= start_tab[clip_sel];
            active_clip            <= clip_sel;
            loop_flag              <= loop_en;
            rate_cnt               <= '0;
            busy                   <= 1'b1;
            left_channel_audio_out <= 32'(sample_nxt_c) << PAD_W;
         end else if (stop_c) begin
            state                  <= IDLE;
            rate_cnt               <= '0;
            busy                   <= 1'b0;
            left_channel_audio_out <= '0;
         end else if (in_play_c) begin
            left_channel_audio_out <= 32'(sample_nxt_c) << PAD_W;
            rate_cnt <= tc_c ? '0 : rate_cnt + CNT_W'(1);
            if (step_c) begin
               rom_address <= at_end_c ? start_tab[active_clip]
                                       : rom_address + ADDR_W'(1);
            end
            if (finish_c) begin
               state                  <= IDLE;
               busy                   <= 1'b0;
               done                   <= 1'b1;
               left_channel_audio_out <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clip_sequencer.sv
// Directed bench for clip_sequencer using small clips and a fast sample rate.
module tb_clip_sequencer;

   localparam int unsigned ADDR_W   = 18;
   localparam int unsigned SAMPLE_W = 6;
   localparam int unsigned SEL_W    = 3;

   logic                CLOCK_50;
   logic                reset;
   logic                trigger;
   logic [SEL_W-1:0]    clip_sel;
   logic                loop_en;
   logic                stop;
   logic [ADDR_W-1:0]   rom_address;
   logic [SAMPLE_W-1:0] rom_q;
   logic                audio_out_allowed;
   logic                write_audio_out;
   logic [31:0]         left_channel_audio_out;
   logic                busy;
   logic [SEL_W-1:0]    active_clip;
   logic                done;

   int checks = 0;
   int errors = 0;

   // clip0 0..5, clip1 6..15, clip2 16..20, clip3 21..40
   clip_sequencer #(
      .ADDR_W(ADDR_W), .SAMPLE_W(SAMPLE_W), .NUM_CLIPS(4), .SEL_W(SEL_W),
      .RATE_DIV(4), .ROM_LAT(2),
      .CLIP_STARTS({18'd21, 18'd16, 18'd6, 18'd0}),
      .CLIP_ENDS({18'd40, 18'd20, 18'd15, 18'd5})
   ) dut (
      .CLOCK_50(CLOCK_50),
      .reset(reset),
      .trigger(trigger),
      .clip_sel(clip_sel),
      .loop_en(loop_en),
      .stop(stop),
      .rom_address(rom_address),
      .rom_q(rom_q),
      .audio_out_allowed(audio_out_allowed),
      .write_audio_out(write_audio_out),
      .left_channel_audio_out(left_channel_audio_out),
      .busy(busy),
      .active_clip(active_clip),
      .done(done)
   );

   initial CLOCK_50 = 1'b0;
   always #5 CLOCK_50 = ~CLOCK_50;

   // ROM model: data = address[5:0], valid by the second edge after an address change
   always_ff @(posedge CLOCK_50) rom_q <= rom_address[5:0];

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK_50);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] pk(input int a);
      logic [5:0] s;
      s = 6'(a);
      return {s, 26'd0};
   endfunction

   initial begin
      reset = 1'b1; trigger = 1'b0; clip_sel = '0; loop_en = 1'b0;
      stop = 1'b0; audio_out_allowed = 1'b0;
      tick(2);
      check("rst_addr", rom_address, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_left", left_channel_audio_out, 0);
      check("rst_write", write_audio_out, 0);
      check("rst_active", active_clip, 0);
      reset = 1'b0; audio_out_allowed = 1'b1;
      tick(1);

      // Clip 0 one-shot
      trigger = 1'b1; clip_sel = 3'd0; loop_en = 1'b0;
      tick(1);
      trigger = 1'b0;
      check("c0_entry_addr", rom_address, 0);
      check("c0_entry_busy", busy, 1);
      check("c0_entry_write", write_audio_out, 0);
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         check("c0_addr", rom_address, (k < 24) ? k / 4 : 5);
         check("c0_busy", busy, (k < 24) ? 1 : 0);
         check("c0_done", done, (k == 24) ? 1 : 0);
         check("c0_write", write_audio_out, (k <= 24) ? 1 : 0);
         check("c0_left", left_channel_audio_out,
               (k < 24) ? pk((k >= 2) ? (k - 2) / 4 : 0) : 32'd0);
      end

      // Clip 2 looping
      trigger = 1'b1; clip_sel = 3'd2; loop_en = 1'b1;
      tick(1);
      trigger = 1'b0; loop_en = 1'b0;
      check("c2_entry_addr", rom_address, 16);
      check("c2_entry_active", active_clip, 2);
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         check("c2_addr", rom_address, 16 + ((k / 4) % 5));
         check("c2_busy", busy, 1);
         check("c2_done", done, 0);
         if (k >= 2) check("c2_left", left_channel_audio_out, pk(16 + (((k - 2) / 4) % 5)));
      end

      // Stop and pre-empting trigger together: stop wins
      stop = 1'b1; trigger = 1'b1; clip_sel = 3'd0;
      tick(1);
      stop = 1'b0; trigger = 1'b0;
      check("stop_busy", busy, 0);
      check("stop_left", left_channel_audio_out, 0);
      check("stop_done", done, 0);
      check("stop_active", active_clip, 2);
      check("stop_addr", rom_address, 18);
      for (int k = 0; k < 6; k++) begin
         tick(1);
         check("stop_idle_done", done, 0);
         check("stop_idle_busy", busy, 0);
      end

      // Clip 3, pre-empted by clip 1, lower-priority trigger ignored, retrigger
      trigger = 1'b1; clip_sel = 3'd3;
      tick(1);
      trigger = 1'b0;
      check("c3_entry_addr", rom_address, 21);
      check("c3_entry_active", active_clip, 3);
      tick(9);
      check("c3_mid_addr", rom_address, 23);
      trigger = 1'b1; clip_sel = 3'd1;
      tick(1);
      trigger = 1'b0;
      check("pre_addr", rom_address, 6);
      check("pre_active", active_clip, 1);
      check("pre_busy", busy, 1);
      tick(1);
      trigger = 1'b1; clip_sel = 3'd3;
      tick(1);
      trigger = 1'b0;
      check("low_prio_addr", rom_address, 6);
      check("low_prio_active", active_clip, 1);
      tick(2);
      check("c1_step_addr", rom_address, 7);
      trigger = 1'b1; clip_sel = 3'd1;
      tick(1);
      trigger = 1'b0;
      check("retrig_addr", rom_address, 6);
      tick(3);
      check("retrig_hold", rom_address, 6);
      tick(1);
      check("retrig_step", rom_address, 7);
      for (int k = 5; k <= 39; k++) begin
         tick(1);
         check("c1_addr", rom_address, (k / 4 > 9) ? 15 : 6 + k / 4);
         check("c1_done", done, 0);
      end

      // Terminal count at end of one-shot with pre-empting trigger: trigger wins
      trigger = 1'b1; clip_sel = 3'd0;
      tick(1);
      trigger = 1'b0;
      check("tc_pre_addr", rom_address, 0);
      check("tc_pre_active", active_clip, 0);
      check("tc_pre_done", done, 0);
      check("tc_pre_busy", busy, 1);

      // Write strobe follows audio_out_allowed one cycle later while busy
      for (int k = 1; k <= 8; k++) begin
         audio_out_allowed = 1'(k % 2);
         tick(1);
         check("tog_write", write_audio_out, k % 2);
         check("tog_addr", rom_address, k / 4);
         if (k >= 2) check("tog_left", left_channel_audio_out, pk((k - 2) / 4));
      end
      audio_out_allowed = 1'b1;
      tick(1);

      // Asynchronous reset mid-clip
      #3 reset = 1'b1;
      #1;
      check("arst_addr", rom_address, 0);
      check("arst_busy", busy, 0);
      check("arst_active", active_clip, 0);
      check("arst_left", left_channel_audio_out, 0);
      check("arst_write", write_audio_out, 0);
      check("arst_done", done, 0);
      #2 reset = 1'b0;
      tick(1);

      // Out-of-range clip selects are ignored
      trigger = 1'b1; clip_sel = 3'd4;
      tick(1);
      trigger = 1'b0;
      check("inv4_busy", busy, 0);
      check("inv4_addr", rom_address, 0);
      trigger = 1'b1; clip_sel = 3'd7;
      tick(1);
      trigger = 1'b0;
      check("inv7_busy", busy, 0);
      check("inv7_active", active_clip, 0);
      tick(2);
      check("inv_done", done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
